// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage owning the PC, the imem req/ready+rvalid
// handshake and the instruction register handed to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic        ImemRValid,
   input  logic [31:0] ImemRData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   input  logic        InstrAccept,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic        MisalignErr,
   output logic [31:0] InstrCount
);
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;
   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d, instr_q, instr_d, pc_q, pc_d, cnt_q, cnt_d;
   logic        mis_q, mis_d;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_FETCH;
         fetch_pc_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         mis_q      <= mis_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      mis_d      = mis_q;
      case (state_q)
         S_FETCH: state_d = ImemReady ? S_WAIT : S_FETCH;
         S_WAIT: if (ImemRValid) begin
            state_d = S_HOLD;
            instr_d = ImemRData;
            pc_d    = fetch_pc_q;
         end
         S_HOLD: if (InstrAccept) begin
            cnt_d   = cnt_q + 32'd1;
            instr_d = NOP_INSTR;
            if (Redirect && |RedirectTarget[1:0]) begin
               mis_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d    = S_FETCH;
               fetch_pc_d = Redirect ? RedirectTarget : PCPlus4;
            end
         end
         default: ;
      endcase
   end
   // Request is masked while reset is held so no fetch escapes the reset cycle.
   assign ImemReq     = reset_n & (state_q == S_FETCH);
   assign ImemAddr    = fetch_pc_q;
   assign InstrValid  = state_q == S_HOLD;
   assign Instr       = instr_q;
   assign PC          = pc_q;
   assign PCPlus4     = pc_q + 32'd4;
   assign MisalignErr = mis_q;
   assign InstrCount  = cnt_q;
endmodule
